// File: rtl/game_score_tracker_if.sv
// Menu/sequencer <-> scoring engine bundle for game_score_tracker.
// The master side (menu + note sequencer) drives start/song and note events;
// the slave side (scoring engine) returns the running/final score and status.
interface game_score_tracker_if;
    logic        start;
    logic [1:0]  song;
    logic        note_hit;
    logic        note_miss;
    logic        song_end;
    logic [17:0] score_bin;
    logic [47:0] score_ascii;
    logic [2:0]  multiplier;
    logic [9:0]  streak;
    logic [1:0]  active_song;
    logic        playing;
    logic        busy;
    logic        done;

    modport master (
        output start, song, note_hit, note_miss, song_end,
        input  score_bin, score_ascii, multiplier, streak, active_song,
               playing, busy, done
    );

    modport slave (
        input  start, song, note_hit, note_miss, song_end,
        output score_bin, score_ascii, multiplier, streak, active_song,
               playing, busy, done
    );
endinterface

// File: rtl/game_score_tracker.sv
// Recorder Hero scoring engine: accumulates hit points with a streak
// multiplier during PLAY, converts the final score to 6 ASCII digits with an
// 18-cycle double-dabble, then pulses done for one cycle.
// Optional feature macro: SCORE_MISS_PENALTY_EN (a miss also subtracts
// MISS_PENALTY from the score, saturating at 0).
module game_score_tracker #(
    parameter int BASE_POINTS  = 50,
    parameter int STREAK_STEP  = 10,
    parameter int MAX_MULT     = 4,
    parameter int MISS_PENALTY = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    game_score_tracker_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAY    = 2'd1,
        S_CONVERT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [17:0] SCORE_MAX  = 18'h3FFFF;
    localparam logic [9:0]  STREAK_MAX = 10'h3FF;
    localparam logic [47:0] ASCII_ZERO = 48'h303030303030;
    localparam logic [4:0]  LAST_ITER  = 5'd17;

    state_t      state_q, state_d;
    logic [17:0] score_q, score_d;
    logic [47:0] ascii_q, ascii_d;
    logic [2:0]  mult_q, mult_d;
    logic [9:0]  streak_q, streak_d;
    logic [1:0]  song_q, song_d;
    logic [17:0] bin_q, bin_d;
    logic [23:0] bcd_q, bcd_d;
    logic [4:0]  cnt_q, cnt_d;

    // Hit path: points use the multiplier in force before this hit.
    logic [20:0] hit_pts;
    logic [20:0] hit_sum;
    logic [17:0] score_hit;
    logic [9:0]  streak_inc;
    logic [10:0] mult_raw;
    logic [2:0]  mult_inc;
    logic [17:0] score_miss;

    assign hit_pts    = 21'(BASE_POINTS) * 21'(mult_q);
    assign hit_sum    = 21'(score_q) + hit_pts;
    assign score_hit  = (hit_sum > 21'(SCORE_MAX)) ? SCORE_MAX : hit_sum[17:0];
    assign streak_inc = (streak_q == STREAK_MAX) ? streak_q : streak_q + 10'd1;
    assign mult_raw   = 11'(streak_inc / 10'(STREAK_STEP)) + 11'd1;
    assign mult_inc   = (mult_raw > 11'(MAX_MULT)) ? 3'(MAX_MULT) : mult_raw[2:0];

`ifdef SCORE_MISS_PENALTY_EN
    assign score_miss = (score_q > 18'(MISS_PENALTY)) ? score_q - 18'(MISS_PENALTY) : 18'd0;
`else
    assign score_miss = score_q;
`endif

    // Double-dabble step: add 3 to every digit >= 5, then shift in next bit.
    logic [23:0] bcd_adj;
    logic [23:0] bcd_shift;
    logic [47:0] ascii_conv;

    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
        assign bcd_adj[gi*4 +: 4]    = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                       bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
        assign ascii_conv[gi*8 +: 8] = {4'h3, bcd_shift[gi*4 +: 4]};
    end
    assign bcd_shift = {bcd_adj[22:0], bin_q[17]};

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            score_q  <= '0;
            ascii_q  <= ASCII_ZERO;
            mult_q   <= 3'd1;
            streak_q <= '0;
            song_q   <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            ascii_q  <= ascii_d;
            mult_q   <= mult_d;
            streak_q <= streak_d;
            song_q   <= song_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic; start overrides everything and restarts a song.
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        ascii_d  = ascii_q;
        mult_d   = mult_q;
        streak_d = streak_q;
        song_d   = song_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: ;
            S_PLAY: begin
                if (bus.note_miss) begin
                    streak_d = '0;
                    mult_d   = 3'd1;
                    score_d  = score_miss;
                end else if (bus.note_hit) begin
                    score_d  = score_hit;
                    streak_d = streak_inc;
                    mult_d   = mult_inc;
                end
                if (bus.song_end) begin
                    state_d = S_CONVERT;
                    bin_d   = score_d;
                    bcd_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_CONVERT: begin
                bin_d = {bin_q[16:0], 1'b0};
                bcd_d = bcd_shift;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    ascii_d = ascii_conv;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (bus.start) begin
            state_d  = S_PLAY;
            score_d  = '0;
            streak_d = '0;
            mult_d   = 3'd1;
            ascii_d  = ASCII_ZERO;
            song_d   = bus.song;
        end
    end

    assign bus.score_bin   = score_q;
    assign bus.score_ascii = ascii_q;
    assign bus.multiplier  = mult_q;
    assign bus.streak      = streak_q;
    assign bus.active_song = song_q;
    assign bus.playing     = (state_q == S_PLAY);
    assign bus.busy        = (state_q == S_CONVERT);
    assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_game_score_tracker.sv
// Scoreboard bench for game_score_tracker: each driven cycle pushes the
// expected outputs of a behavioural model, popped and compared after the edge.
module tb_game_score_tracker;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    game_score_tracker_if bus ();

    game_score_tracker dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [17:0] score;
        logic [47:0] ascii;
        logic [2:0]  mult;
        logic [9:0]  streak;
        logic [1:0]  song;
        logic        playing;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state (0 idle, 1 play, 2 convert, 3 done).
    int          m_state;
    int          m_score;
    int          m_mult;
    int          m_streak;
    int          m_cnt;
    logic [1:0]  m_song;
    logic [47:0] m_ascii;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [47:0] to_ascii(input int v);
        logic [47:0] r;
        int x;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[i*8 +: 8] = 8'h30 + 8'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_step(input logic rst, input logic st, input logic [1:0] sg,
                              input logic hit, input logic miss, input logic send);
        if (rst) begin
            m_state = 0; m_score = 0; m_mult = 1; m_streak = 0; m_cnt = 0;
            m_song = 2'd0; m_ascii = 48'h303030303030;
        end else if (st) begin
            m_state = 1; m_score = 0; m_mult = 1; m_streak = 0;
            m_song = sg; m_ascii = 48'h303030303030;
        end else begin
            case (m_state)
                1: begin
                    if (miss) begin
                        m_streak = 0;
                        m_mult = 1;
`ifdef SCORE_MISS_PENALTY_EN
                        m_score = (m_score > 25) ? m_score - 25 : 0;
`endif
                    end else if (hit) begin
                        m_score = m_score + 50 * m_mult;
                        if (m_score > 262143) m_score = 262143;
                        if (m_streak < 1023) m_streak++;
                        m_mult = 1 + m_streak / 10;
                        if (m_mult > 4) m_mult = 4;
                    end
                    if (send) begin
                        m_state = 2;
                        m_cnt = 0;
                    end
                end
                2: begin
                    m_cnt++;
                    if (m_cnt == 18) begin
                        m_state = 3;
                        m_ascii = to_ascii(m_score);
                    end
                end
                3: m_state = 0;
                default: m_state = 0;
            endcase
        end
    endtask

    // One clock: drive at negedge, push model expectation, compare after posedge.
    task automatic step(input logic rst, input logic st, input logic [1:0] sg,
                        input logic hit, input logic miss, input logic send);
        exp_t e;
        reset         = rst;
        bus.start     = st;
        bus.song      = sg;
        bus.note_hit  = hit;
        bus.note_miss = miss;
        bus.song_end  = send;
        model_step(rst, st, sg, hit, miss, send);
        e.score   = 18'(m_score);
        e.ascii   = m_ascii;
        e.mult    = 3'(m_mult);
        e.streak  = 10'(m_streak);
        e.song    = m_song;
        e.playing = (m_state == 1);
        e.busy    = (m_state == 2);
        e.done    = (m_state == 3);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("score_bin",   64'(bus.score_bin),   64'(e.score));
        check_val("score_ascii", 64'(bus.score_ascii), 64'(e.ascii));
        check_val("multiplier",  64'(bus.multiplier),  64'(e.mult));
        check_val("streak",      64'(bus.streak),      64'(e.streak));
        check_val("active_song", 64'(bus.active_song), 64'(e.song));
        check_val("playing",     64'(bus.playing),     64'(e.playing));
        check_val("busy",        64'(bus.busy),        64'(e.busy));
        check_val("done",        64'(bus.done),        64'(e.done));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.song = 2'd0;
        bus.note_hit = 1'b0; bus.note_miss = 1'b0; bus.song_end = 1'b0;
        @(negedge clk);

        // Reset state, then events in IDLE must be ignored.
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        $display("txn reset/idle-ignore score=%0d", bus.score_bin);

        // Song 2: 12 hits -> 700, ASCII "000700" with done 19 cycles after song_end.
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        hits(12);
        check_val("t1_mult_after12", 64'(bus.multiplier), 64'd2);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(20);
        check_val("t1_score", 64'(bus.score_bin), 64'd700);
        check_val("t1_ascii", 64'(bus.score_ascii), 64'h303030373030);
        $display("txn song2 12 hits score=%0d ascii=%s", bus.score_bin, bus.score_ascii);

        // 5 hits then hit+miss in one cycle.
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        hits(5);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
`ifdef SCORE_MISS_PENALTY_EN
        check_val("t2_score", 64'(bus.score_bin), 64'd225);
`else
        check_val("t2_score", 64'(bus.score_bin), 64'd250);
`endif
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(20);
        $display("txn hit+miss score=%0d", bus.score_bin);

        // 1 hit, 3 misses (penalty floor when enabled).
        step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        hits(1);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        idle(20);
        $display("txn misses score=%0d", bus.score_bin);

        // Saturation: 1400 hits at MAX_MULT.
        step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        hits(1400);
        check_val("t4_sat", 64'(bus.score_bin), 64'd262143);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        idle(20);
        check_val("t4_ascii", 64'(bus.score_ascii), 64'h323632313433);
        $display("txn saturate score=%0d ascii=%s", bus.score_bin, bus.score_ascii);

        // Abort during CONVERT: start at cycle 5, no done must ever appear.
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        hits(3);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(4);
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        check_val("t5_busy", 64'(bus.busy), 64'd0);
        check_val("t5_ascii", 64'(bus.score_ascii), 64'h303030303030);
        hits(2);
        idle(25);
        $display("txn abort-in-convert playing=%0d", bus.playing);

        // Reset mid-PLAY at score 400; later hit/song_end ignored.
        step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        hits(8);
        check_val("t6_pre", 64'(bus.score_bin), 64'd400);
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(22);
        $display("txn reset-mid-play score=%0d", bus.score_bin);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
